// File: rtl/johnson_phase_decoder.sv
// Decodes an upstream Johnson counter into a phase index, tracks step continuity,
// and flags illegal codes, phase skips and cycle wraps with a saturating error count.
module johnson_phase_decoder #(
  parameter int SIZE     = 7,
  parameter int LOCK_CNT = 4
) (
  input  logic                                clk,
  input  logic                                r,
  input  logic [0:SIZE]                       jc_in,
  input  logic                                err_clr,
  output logic [$clog2(2*(SIZE+1))-1:0]       phase,
  output logic                                phase_valid,
  output logic [2*(SIZE+1)-1:0]               phase_oh,
  output logic                                locked,
  output logic                                illegal,
  output logic                                skip,
  output logic                                wrap,
  output logic [7:0]                          err_cnt
);
  localparam int N  = SIZE + 1;
  localparam int M  = 2 * N;
  localparam int PW = $clog2(M);
  localparam int CW = $clog2(N + 1);
  localparam int RW = $clog2(LOCK_CNT + 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t          state;
  logic [PW-1:0]   prev_phase;
  logic            prev_valid;
  logic [RW-1:0]   run;

  logic [CW-1:0]   pc, trans;
  logic            legal, succ, hold, err_ev;
  logic [PW-1:0]   dec, succ_ph;
  logic [RW-1:0]   run_nxt;

  // A legal Johnson word has at most one 0/1 boundary along the bit string;
  // bit 0 tells which half of the cycle we are in.
  always_comb begin
    pc    = '0;
    trans = '0;
    for (int i = 0; i < N; i++) pc = pc + CW'(jc_in[i]);
    for (int i = 0; i < N - 1; i++) trans = trans + CW'(jc_in[i] ^ jc_in[i+1]);
    legal = (trans <= CW'(1));
    if (jc_in[0])        dec = PW'(pc);
    else if (pc == '0)   dec = '0;
    else                 dec = PW'(M - int'(pc));
  end

  assign succ_ph = (prev_phase == PW'(M - 1)) ? '0 : prev_phase + PW'(1);
  assign succ    = legal && prev_valid && (dec == succ_ph);
  assign hold    = legal && prev_valid && (dec == prev_phase);
  assign err_ev  = !legal || (prev_valid && !succ && !hold);
  assign run_nxt = (run == RW'(LOCK_CNT)) ? run : run + RW'(1);

  assign phase  = prev_phase;
  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state       <= UNLOCKED;
      prev_phase  <= '0;
      prev_valid  <= 1'b0;
      run         <= '0;
      phase_valid <= 1'b0;
      phase_oh    <= '0;
      illegal     <= 1'b0;
      skip        <= 1'b0;
      wrap        <= 1'b0;
      err_cnt     <= '0;
    end else begin
      illegal <= 1'b0;
      skip    <= 1'b0;
      wrap    <= 1'b0;

      // Clear has priority over a same-cycle error.
      if (err_clr)                          err_cnt <= '0;
      else if (err_ev && err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;

      if (!legal) begin
        illegal     <= 1'b1;
        phase_valid <= 1'b0;
        phase_oh    <= '0;
        run         <= '0;
        state       <= UNLOCKED;
      end else begin
        phase_valid <= 1'b1;
        prev_phase  <= dec;
        prev_valid  <= 1'b1;
        phase_oh    <= {{(M-1){1'b0}}, 1'b1} << dec;
        if (succ) begin
          run  <= run_nxt;
          wrap <= (prev_phase == PW'(M - 1));
          if (run_nxt == RW'(LOCK_CNT)) state <= LOCKED;
        end else if (prev_valid && !hold) begin
          skip  <= 1'b1;
          run   <= '0;
          state <= UNLOCKED;
        end
      end
    end
  end
endmodule

// File: doc/johnson_phase_decoder.md
JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

Interface
REQ-001 SHALL have parameter SIZE, default 7; code width is SIZE+1 and the cycle length is 2*(SIZE+1), which is 16 at default.
REQ-002 SHALL have parameter LOCK_CNT, default 4: the number of consecutive successor codes required to reach lock.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port r, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port jc_in[0:SIZE], input, SIZE+1 bits: Johnson code from the upstream counter; bit 0 is the shift-in end.
REQ-006 SHALL have port err_clr, input, 1 bit: synchronous clear of err_cnt.
REQ-007 SHALL have port phase, output, clog2(2*(SIZE+1)) bits (4 at default): decoded phase index.
REQ-008 SHALL have port phase_valid, output, 1 bit: the last sampled code was legal.
REQ-009 SHALL have port phase_oh, output, 2*(SIZE+1) bits: one-hot of phase, all zero when phase_valid=0.
REQ-010 SHALL have port locked, output, 1 bit: FSM in LOCKED.
REQ-011 SHALL have ports illegal, skip and wrap, each output, 1 bit: single-cycle event pulses.
REQ-012 SHALL have port err_cnt, output, 8 bits: saturating error count.

Function
REQ-013 Legal code table SHALL be as follows (N=SIZE+1):
- phase k, 0<=k<=N: bits 0..k-1 = 1, rest 0 (phase 0 = all zeros, phase N = all ones).
- phase N+j, 1<=j<N: bits 0..j-1 = 0, rest 1.
- Any other pattern is illegal.
REQ-014 Every rising edge SHALL sample jc_in, decode it and register all outputs; latency is 1 cycle from jc_in to outputs.
REQ-015 Internal state SHALL be prev_phase, prev_valid, run counter (0..LOCK_CNT), and FSM {UNLOCKED, LOCKED}.
REQ-016 Illegal code SHALL cause:
- illegal=1 and phase_valid=0 for one cycle;
- phase, prev_phase and prev_valid held;
- err_cnt incremented;
- run=0; FSM->UNLOCKED.
REQ-017 A legal code with prev_valid=0 SHALL load phase and prev_phase, set prev_valid=1 and phase_valid=1, and raise no skip.
REQ-018 A legal code equal to (prev_phase+1) mod 2N SHALL be a successor:
- run increments, saturating at LOCK_CNT;
- when run reaches LOCK_CNT in UNLOCKED, FSM->LOCKED and locked=1 from the same edge.
REQ-019 A legal code equal to prev_phase SHALL be a hold: no change to run or FSM, and no pulse.
REQ-020 Any other legal code SHALL be a skip:
- skip=1 for one cycle; phase updated;
- err_cnt incremented; run=0; FSM->UNLOCKED.
REQ-021 wrap SHALL pulse for one cycle on the successor from phase 2N-1 to phase 0, independent of lock state.
REQ-022 err_cnt SHALL saturate at 255 and never wrap.
REQ-023 err_clr=1 SHALL set err_cnt to 0 on that edge; clear wins over a simultaneous error increment.
REQ-024 illegal, skip and wrap SHALL be mutually exclusive in any cycle.

Reset
REQ-025 While r=1, outputs SHALL be:
- phase=0, phase_valid=0, phase_oh=0, locked=0;
- illegal=0, skip=0, wrap=0, err_cnt=0.
REQ-026 While r=1, internal state SHALL be prev_valid=0, run=0, FSM=UNLOCKED.
REQ-027 Reset asserted mid-lock SHALL clear all state immediately, without waiting for a clock edge; the first edge after release is treated as the first code (REQ-017).

Verification
REQ-028 Reset, then drive jc_in = 00000000, 10000000, 11000000, 11100000, 11110000 on successive edges -> phase 0,1,2,3,4 with 1-cycle latency; locked=1 on the edge that samples 11110000; err_cnt=0.
REQ-029 Run a full 16-code cycle twice -> wrap pulses exactly once per 15->0 transition; phase_oh = 1<<phase on every cycle.
REQ-030 While locked, drive 10100000 -> illegal=1, phase_valid=0, phase_oh=0, locked=0, err_cnt=1; phase holds its previous value.
REQ-031 While locked at phase 3, drive phase 6 code 11111100 -> skip=1, phase=6, locked=0, err_cnt increments; 4 more successors -> locked=1.
REQ-032 Hold the same legal code for 10 cycles, then resume successors -> no pulses, run unchanged, lock state retained.
REQ-033 Force 260 illegal codes -> err_cnt=255; err_clr asserted together with an illegal code -> err_cnt=0; assert r asynchronously mid-cycle -> all outputs 0 before the next edge.
